serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor. It processes WIDTH-bit operands one bit per clock through a single 1-bit full-adder cell, with the carry held in a register between bits. A start/busy/done handshake lets it sit behind a simple controller in the datapath exercises. It replaces wide combinational adders where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request a new operation; sampled only in IDLE
sub  input  1  0 = add (a+b+ci), 1 = subtract (a-b); latched on start
a  input  WIDTH  operand a; latched on start
b  input  WIDTH  operand b; latched on start
ci  input  1  carry in for add; latched on start; ignored when sub=1
s  output  WIDTH  result; registered
co  output  1  carry out in add mode; not-borrow in subtract mode (1 = no borrow)
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when s/co become valid
ovf  output  1  signed overflow (present only with SERIAL_ADDER_OVF_EN)

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE; s=0, co=0, busy=0, done=0, ovf=0; bit counter=0; carry register=0; operand registers=0. No partial result is retained.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge T, then:
  - latch a; latch b_eff = sub ? ~b : b; set carry = sub ? 1 : ci.
  - clear s and co to 0, counter=0, state to RUN.
  - start=0 leaves the state in IDLE with s/co holding their values.
- RUN: at edges T+1..T+WIDTH, one bit per edge, LSB first:
  - s[cnt] <= a[cnt] ^ b_eff[cnt] ^ carry.
  - carry <= majority(a[cnt], b_eff[cnt], carry).
  - cnt increments.
  - At the edge where cnt==WIDTH-1: co <= final carry, state to DONE, cnt wraps to 0.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE at edge T+WIDTH+1.
- Output timing:
  - busy = (state==RUN), decoded from registered state.
  - done = (state==DONE), high for exactly one cycle after edge T+WIDTH.
  - Latency from the accepting edge to the done cycle is WIDTH edges.
- start in RUN or DONE: ignored, with no queuing. A start held high through DONE is accepted at the first IDLE edge. Back-to-back throughput is therefore one operation per WIDTH+2 cycles.
- Inputs a/b/sub/ci changing during RUN have no effect.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Subtract uses two's complement (b inverted, carry-in forced to 1).
  - co=0 after a subtract means a<b (unsigned).
- Counter width: $clog2(WIDTH).

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - ovf port exists.
  - On the final bit, ovf <= carry_into_msb ^ carry_out_of_msb.
  - ovf is cleared on an accepted start, is valid with done, and holds until the next accepted start.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - helper localparam for counter width.
- Sub-module fa_cell: purely combinational 1-bit full adder (a, b, ci -> s, co), instantiated once. The FSM, counter and registers stay in serial_adder.

Test Plan:
- WIDTH=8, add: a=8'h5A, b=8'h3C, ci=0, start at edge T.
  - busy high for 8 cycles; done pulses in the cycle after edge T+8.
  - s=8'h96, co=0.
- Add with carry-in: a=8'hFF, b=8'h01, ci=1 -> s=8'h01, co=1.
- Subtract: sub=1, a=8'h10, b=8'h20 -> s=8'hF0, co=0 (borrow).
  - Also a=8'h20, b=8'h10 -> s=8'h10, co=1.
- With SERIAL_ADDER_OVF_EN:
  - 8'h7F+8'h01 -> s=8'h80, ovf=1.
  - 8'h80-8'h01 -> s=8'h7F, ovf=1.
  - 8'h05+8'h03 -> ovf=0.
- start pulsed and operands changed during RUN:
  - Ignored; the result matches the original operands.
  - A start held through DONE is accepted on the following IDLE edge.
- rst asserted at the 4th bit of RUN:
  - All outputs 0 immediately (asynchronously), state IDLE.
  - A fresh start afterwards produces a correct result.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding and
// the counter-width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultCntW  = cnt_width(DefaultWidth);

endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder; the only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, one bit per clock LSB first through one fa_cell.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif
    logic             bit_s, bit_co;

    fa_cell u_fa (
        .a  (a_q[cnt_q]),
        .b  (b_q[cnt_q]),
        .ci (carry_q),
        .s  (bit_s),
        .co (bit_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + 1, so ci is ignored in that mode.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : ci;
                    s_d     = '0;
                    co_d    = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[cnt_q] = bit_s;
                carry_d    = bit_co;
                if (cnt_q == LastBit) begin
                    co_d    = bit_co;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ bit_co;
`endif
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations
// against an integer-arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk, rst, start, sub, ci;
    logic [W-1:0] a, b, s;
    logic         co, busy, done;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .s     (s),
        .co    (co),
        .busy  (busy),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: modulo result, unsigned carry/no-borrow, signed range test.
    function automatic void ref_model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                      input logic osub, input logic oci,
                                      output logic [W-1:0] rs, output logic rco,
                                      output logic rovf);
        longint ua, ub, sa, sb, ur, sr, smax, smin;
        ua   = longint'(oa);
        ub   = longint'(ob);
        sa   = longint'($signed(oa));
        sb   = longint'($signed(ob));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        if (osub) begin
            ur  = ua - ub;
            sr  = sa - sb;
            rco = (ua >= ub);
        end else begin
            ur  = ua + ub + longint'(oci);
            sr  = sa + sb + longint'(oci);
            rco = (ur >= (longint'(1) << W));
        end
        rs   = W'(ur);
        rovf = (sr > smax) || (sr < smin);
    endfunction

    // Issues one op from IDLE and follows it to DONE. poke scrambles inputs and
    // start during RUN; hold keeps start high and returns while still in DONE.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic osub, input logic oci,
                          input bit poke, input bit hold, input string tag);
        logic [W-1:0] e_s;
        logic         e_co, e_ovf;
        int           busy_cycles;
        ref_model(oa, ob, osub, oci, e_s, e_co, e_ovf);
        a = oa; b = ob; sub = osub; ci = oci; start = 1'b1;
        @(posedge clk); #1;
        busy_cycles = 0;
        for (int k = 0; k < int'(W); k++) begin
            if (busy && !done) busy_cycles++;
            start = hold ? 1'b1 : (poke ? 1'($urandom) : 1'b0);
            if (poke) begin
                a   = W'($urandom);
                b   = W'($urandom);
                sub = 1'($urandom);
                ci  = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        check_eq({tag, " busy_cycles"}, 64'(busy_cycles), 64'(W));
        check_eq({tag, " done"}, 64'(done), 64'd1);
        check_eq({tag, " busy_in_done"}, 64'(busy), 64'd0);
        check_eq({tag, " s"}, 64'(s), 64'(e_s));
        check_eq({tag, " co"}, 64'(co), 64'(e_co));
`ifdef SERIAL_ADDER_OVF_EN
        check_eq({tag, " ovf"}, 64'(ovf), 64'(e_ovf));
`endif
        if (!hold) begin
            start = 1'b0;
            @(posedge clk); #1;
            check_eq({tag, " done_pulse_end"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        #1;
        check_eq("reset s", 64'(s), 64'd0);
        check_eq("reset co", 64'(co), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset done", 64'(done), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("reset ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle busy", 64'(busy), 64'd0);

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, "add_ff_01_ci");
        run_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, "sub_10_20");
        run_op(8'h20, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, "sub_20_10");
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, "add_7f_01");
        run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, "sub_80_01");
        run_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, "add_05_03");

        // Inputs churn during RUN, and start stays high through DONE.
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, "poke_hold");
        @(posedge clk); #1;
        check_eq("hold idle busy", 64'(busy), 64'd0);
        check_eq("hold idle done", 64'(done), 64'd0);
        run_op(8'hC3, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, "held_accept");

        // Asynchronous reset while the 4th bit is in progress.
        a = 8'hFF; b = 8'h00; sub = 1'b0; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrun rst s", 64'(s), 64'd0);
        check_eq("midrun rst co", 64'(co), 64'd0);
        check_eq("midrun rst busy", 64'(busy), 64'd0);
        check_eq("midrun rst done", 64'(done), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("midrun rst ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post rst idle", 64'(busy), 64'd0);
        run_op(8'h96, 8'h6B, 1'b0, 1'b1, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
